// File: rtl/brush_pkg.sv
// rtl/brush_pkg.sv - shared state encoding and screen limits for the brush path
//
// Purpose: types and constants shared by the camera centroid stage, the
//          brush tracker and the drawing frame buffer.
// Contents:
//   SCREEN_W / SCREEN_H  visible drawing area in pixels
//   tracker_state_t      tracker state encoding (also shown on debug LEDs)
//   out_mode_t           what the output stage does on the cycle after a frame
//   abs_diff10           unsigned |a - b| on 10-bit coordinates
package brush_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [8:0] SCREEN_H = 9'd360;

  typedef enum logic [1:0] {
    LOST    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    COAST   = 2'd3
  } tracker_state_t;

  typedef enum logic [1:0] {
    OUT_HOLD     = 2'd0,
    OUT_LOAD     = 2'd1,
    OUT_DEADBAND = 2'd2
  } out_mode_t;

  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/brush_tracker_sample_history.sv
// rtl/brush_tracker_sample_history.sv - per-axis ring buffer with running sum
//
// Purpose: keeps the last 2^DEPTH_LOG2 samples of one coordinate axis and
//          their sum, so the average is a plain shift of the sum.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset (pointer and sum clear)
//   push  in   replace the oldest entry with din
//   fill  in   overwrite every entry with din (takes priority over push)
//   din   in   WIDTH-bit sample
//   sum   out  (WIDTH+DEPTH_LOG2)-bit sum of all entries
module sample_history #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        fill,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH+DEPTH_LOG2-1:0] sum
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = WIDTH + DEPTH_LOG2;
  localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [SW-1:0]    r_sum;
  logic [WIDTH-1:0] w_oldest;

  // The write pointer always addresses the oldest entry, which is the one
  // leaving the window on the next push.
  assign w_oldest = r_mem[r_wptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_sum  <= '0;
    end else if (fill) begin
      r_wptr <= '0;
      r_sum  <= SW'(din) << DEPTH_LOG2;
    end else if (push) begin
      r_wptr <= r_wptr + PW'(1);
      // Modular arithmetic: the true sum never goes negative, so the
      // intermediate wrap cancels out.
      r_sum  <= r_sum + SW'(din) - SW'(w_oldest);
    end
  end

  // Entry contents need no reset: every path into use starts with a fill.
  always_ff @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= din;
      end
    end else if (push) begin
      r_mem[r_wptr] <= din;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/brush_tracker.sv
// rtl/brush_tracker.sv - per-frame brush cursor conditioner
//
// Purpose: latches the last in-range centroid of each video frame, classifies
//          the frame as hit/miss at the new-frame pulse, averages recent hits
//          and drives deadbanded coordinates that only move at frame edges.
// Ports:
//   pixel_clk_in       in   sole clock
//   rst_in             in   asynchronous active-high reset
//   centroid_valid_in  in   one-cycle strobe, x_in/y_in hold a centroid
//   x_in / y_in        in   raw centroid (10 / 9 bits)
//   nf_in              in   one-cycle new-frame pulse
//   x_out / y_out      out  conditioned coordinates, held across a frame
//   active_out         out  pen down (TRACK or COAST)
//   update_out         out  one-cycle strobe when x_out/y_out change
//   state_out          out  current tracker_state_t encoding
module brush_tracker
  import brush_pkg::*;
#(
  parameter int WINDOW_LOG2    = 2,
  parameter int ACQUIRE_FRAMES = 3,
  parameter int LOST_FRAMES    = 8,
  parameter int DEADBAND       = 2
) (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic       centroid_valid_in,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  input  logic       nf_in,
  output logic [9:0] x_out,
  output logic [8:0] y_out,
  output logic       active_out,
  output logic       update_out,
  output logic [1:0] state_out
);

  localparam int HW = $clog2(ACQUIRE_FRAMES + 1);
  localparam int MW = $clog2(LOST_FRAMES + 1);
  localparam logic [HW-1:0] ACQ_N  = HW'(ACQUIRE_FRAMES);
  localparam logic [MW-1:0] LOST_N = MW'(LOST_FRAMES);
  localparam logic [9:0]    DB     = 10'(DEADBAND);

  // Sample latch
  logic       w_strobe_ok;
  logic       r_have_sample;
  logic [9:0] r_sx;
  logic [8:0] r_sy;

  // Frame state machine
  tracker_state_t r_state, w_state_nx;
  logic [HW-1:0]  r_hit_cnt, w_hit_nx, w_hit_inc;
  logic [MW-1:0]  r_miss_cnt, w_miss_nx, w_miss_inc;
  logic           w_push, w_fill;
  out_mode_t      r_mode, w_mode_nx;

  // Averaging and output stage
  logic [9+WINDOW_LOG2:0] w_sum_x;
  logic [8+WINDOW_LOG2:0] w_sum_y;
  logic [9:0]             w_avg_x;
  logic [8:0]             w_avg_y;
  logic [9:0]             w_dx, w_dy;
  logic                   w_mv_x, w_mv_y;
  logic                   w_unused_sum_lsbs;
  logic [9:0]             r_x;
  logic [8:0]             r_y;
  logic                   r_active;
  logic                   r_update;

  assign w_strobe_ok = centroid_valid_in && (x_in < SCREEN_W) && (y_in < SCREEN_H);

  // A strobe coincident with nf_in is kept for the frame that is starting,
  // while the frame that is ending is judged on the old have_sample/r_sx/r_sy.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_have_sample <= 1'b0;
      r_sx          <= '0;
      r_sy          <= '0;
    end else begin
      if (nf_in) begin
        r_have_sample <= w_strobe_ok;
      end else if (w_strobe_ok) begin
        r_have_sample <= 1'b1;
      end
      if (w_strobe_ok) begin
        r_sx <= x_in;
        r_sy <= y_in;
      end
    end
  end

  assign w_hit_inc  = r_hit_cnt + HW'(1);
  assign w_miss_inc = r_miss_cnt + MW'(1);

  always_comb begin
    w_state_nx = r_state;
    w_hit_nx   = r_hit_cnt;
    w_miss_nx  = r_miss_cnt;
    w_push     = 1'b0;
    w_fill     = 1'b0;
    w_mode_nx  = OUT_HOLD;
    if (nf_in) begin
      case (r_state)
        LOST: begin
          if (r_have_sample) begin
            w_fill   = 1'b1;
            w_hit_nx = HW'(1);
            if (ACQUIRE_FRAMES <= 1) begin
              w_state_nx = TRACK;
              w_mode_nx  = OUT_LOAD;
            end else begin
              w_state_nx = ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (r_have_sample) begin
            w_push = 1'b1;
            if (w_hit_inc >= ACQ_N) begin
              w_state_nx = TRACK;
              w_hit_nx   = '0;
              w_mode_nx  = OUT_LOAD;
            end else begin
              w_hit_nx = w_hit_inc;
            end
          end else begin
            w_state_nx = LOST;
            w_hit_nx   = '0;
          end
        end
        TRACK: begin
          if (r_have_sample) begin
            w_push    = 1'b1;
            w_mode_nx = OUT_DEADBAND;
          end else if (LOST_FRAMES <= 1) begin
            w_state_nx = LOST;
          end else begin
            w_state_nx = COAST;
            w_miss_nx  = MW'(1);
          end
        end
        COAST: begin
          if (r_have_sample) begin
            w_state_nx = TRACK;
            w_push     = 1'b1;
            w_miss_nx  = '0;
            w_mode_nx  = OUT_DEADBAND;
          end else if (w_miss_inc >= LOST_N) begin
            w_state_nx = LOST;
            w_miss_nx  = '0;
          end else begin
            w_miss_nx = w_miss_inc;
          end
        end
        default: w_state_nx = LOST;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= LOST;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_mode     <= OUT_HOLD;
    end else begin
      r_state    <= w_state_nx;
      r_hit_cnt  <= w_hit_nx;
      r_miss_cnt <= w_miss_nx;
      r_mode     <= w_mode_nx;
    end
  end

  sample_history #(.WIDTH(10), .DEPTH_LOG2(WINDOW_LOG2)) u_hist_x (
    .clk  (pixel_clk_in),
    .rst  (rst_in),
    .push (w_push),
    .fill (w_fill),
    .din  (r_sx),
    .sum  (w_sum_x)
  );

  sample_history #(.WIDTH(9), .DEPTH_LOG2(WINDOW_LOG2)) u_hist_y (
    .clk  (pixel_clk_in),
    .rst  (rst_in),
    .push (w_push),
    .fill (w_fill),
    .din  (r_sy),
    .sum  (w_sum_y)
  );

  // Truncating average: drop the low WINDOW_LOG2 bits of the sum.
  assign w_avg_x           = w_sum_x[WINDOW_LOG2 +: 10];
  assign w_avg_y           = w_sum_y[WINDOW_LOG2 +: 9];
  assign w_unused_sum_lsbs = ^{w_sum_x[WINDOW_LOG2-1:0], w_sum_y[WINDOW_LOG2-1:0]};

  assign w_dx   = abs_diff10(w_avg_x, r_x);
  assign w_dy   = abs_diff10({1'b0, w_avg_y}, {1'b0, r_y});
  assign w_mv_x = (w_dx > DB);
  assign w_mv_y = (w_dy > DB);

  // r_mode is a one-cycle tag set by the frame evaluation, so the output
  // registers act exactly two cycles after nf_in and hold otherwise.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x      <= '0;
      r_y      <= '0;
      r_active <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_active <= (r_state == TRACK) || (r_state == COAST);
      r_update <= 1'b0;
      case (r_mode)
        OUT_LOAD: begin
          r_x      <= w_avg_x;
          r_y      <= w_avg_y;
          r_update <= (w_avg_x != r_x) || (w_avg_y != r_y);
        end
        OUT_DEADBAND: begin
          if (w_mv_x) r_x <= w_avg_x;
          if (w_mv_y) r_y <= w_avg_y;
          r_update <= w_mv_x || w_mv_y;
        end
        default: ;
      endcase
    end
  end

  assign x_out      = r_x;
  assign y_out      = r_y;
  assign active_out = r_active;
  assign update_out = r_update;
  assign state_out  = r_state;

endmodule

// File: tb/tb_brush_tracker.sv
// tb/tb_brush_tracker.sv - self-checking bench for brush_tracker
module tb_brush_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cv  = 1'b0;
  logic       nf  = 1'b0;
  logic [9:0] xi  = '0;
  logic [8:0] yi  = '0;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic       active_out;
  logic       update_out;
  logic [1:0] state_out;

  brush_tracker dut (
    .pixel_clk_in      (clk),
    .rst_in            (rst),
    .centroid_valid_in (cv),
    .x_in              (xi),
    .y_in              (yi),
    .nf_in             (nf),
    .x_out             (x_out),
    .y_out             (y_out),
    .active_out        (active_out),
    .update_out        (update_out),
    .state_out         (state_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int upd_total = 0;

  always @(negedge clk) if (update_out) upd_total++;

  typedef struct {
    bit hit; int x; int y;
    int ex; int ey; int ea; int es; int eu;
  } vec_t;
  vec_t vecs[$];

  // Reference model state
  int m_state, m_hits, m_miss, m_x, m_y, m_act, m_upd;
  int hist_x[$];
  int hist_y[$];
  bit pend_v;
  int pend_x, pend_y;

  function automatic void add(bit h, int x, int y, int ex, int ey, int ea, int es, int eu);
    vecs.push_back('{h, x, y, ex, ey, ea, es, eu});
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int x, input int y);
    tick();
    cv = 1'b1; xi = 10'(x); yi = 9'(y);
    tick();
    cv = 1'b0;
  endtask

  task automatic nf_pulse(input bit co, input int x, input int y);
    tick();
    nf = 1'b1;
    if (co) begin cv = 1'b1; xi = 10'(x); yi = 9'(y); end
    tick();
    nf = 1'b0; cv = 1'b0;
  endtask

  task automatic frm(input int ns, input int x0, input int y0, input int x1, input int y1,
                     input bit co, input int cx, input int cy, output int upd);
    int base;
    tick();
    base = upd_total;
    if (ns > 0) strobe(x0, y0);
    if (ns > 1) strobe(x1, y1);
    nf_pulse(co, cx, cy);
    tick();
    tick();
    upd = upd_total - base;
  endtask

  task automatic check_frame(input string tag, input int ex, input int ey, input int ea,
                             input int es, input int eu, input int upd);
    chk({tag, " x_out"}, int'(x_out), ex);
    chk({tag, " y_out"}, int'(y_out), ey);
    chk({tag, " active_out"}, int'(active_out), ea);
    chk({tag, " state_out"}, int'(state_out), es);
    chk({tag, " update pulses"}, upd, eu);
  endtask

  task automatic do_reset();
    tick();
    #2 rst = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
  endtask

  // ---- reference model: frame rules applied to a queue of recent hits ----
  function automatic int avg_of(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / q.size();
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_reset();
    m_state = 0; m_hits = 0; m_miss = 0; m_x = 0; m_y = 0; m_act = 0; m_upd = 0;
    hist_x.delete(); hist_y.delete(); pend_v = 0; pend_x = 0; pend_y = 0;
  endtask

  task automatic m_strobe(input int x, input int y);
    if (x < 640 && y < 360) begin pend_v = 1; pend_x = x; pend_y = y; end
  endtask

  task automatic m_push(input int x, input int y);
    hist_x.push_back(x); void'(hist_x.pop_front());
    hist_y.push_back(y); void'(hist_y.pop_front());
  endtask

  task automatic m_output(input bit unconditional);
    int ax, ay;
    bit cx, cy;
    ax = avg_of(hist_x); ay = avg_of(hist_y);
    cx = unconditional ? (ax != m_x) : (iabs(ax - m_x) > 2);
    cy = unconditional ? (ay != m_y) : (iabs(ay - m_y) > 2);
    if (cx) m_x = ax;
    if (cy) m_y = ay;
    m_upd = (cx || cy) ? 1 : 0;
  endtask

  task automatic m_frame();
    bit hit;
    int sx, sy;
    hit = pend_v; sx = pend_x; sy = pend_y; pend_v = 0;
    m_upd = 0;
    case (m_state)
      0: if (hit) begin
           hist_x.delete(); hist_y.delete();
           for (int i = 0; i < 4; i++) begin hist_x.push_back(sx); hist_y.push_back(sy); end
           m_hits = 1; m_state = 1;
         end
      1: if (hit) begin
           m_push(sx, sy); m_hits++;
           if (m_hits >= 3) begin m_state = 2; m_output(1'b1); end
         end else m_state = 0;
      2: if (hit) begin m_push(sx, sy); m_output(1'b0); end
         else begin m_state = 3; m_miss = 1; end
      default: if (hit) begin m_state = 2; m_miss = 0; m_push(sx, sy); m_output(1'b0); end
         else begin m_miss++; if (m_miss >= 8) m_state = 0; end
    endcase
    m_act = (m_state == 2 || m_state == 3) ? 1 : 0;
  endtask

  task automatic gen(output int x, output int y);
    if ($urandom_range(0, 1) == 0) begin
      x = $urandom_range(0, 639); y = $urandom_range(0, 359);
    end else begin
      x = m_x + int'($urandom_range(0, 12)) - 6;
      y = m_y + int'($urandom_range(0, 12)) - 6;
      x = (x < 0) ? 0 : ((x > 639) ? 639 : x);
      y = (y < 0) ? 0 : ((y > 359) ? 359 : y);
    end
    if ($urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 0) x = 640 + int'($urandom_range(0, 383));
      else y = 360 + int'($urandom_range(0, 151));
    end
  endtask

  initial begin
    int upd, base, thr, ns, sx, sy, cx, cy;
    bit co;

    // ---- reset state and reset release ----
    tick(); tick();
    check_frame("reset", 0, 0, 0, 0, 0, upd_total);
    #2 rst = 1'b0;
    tick(); tick(); tick();
    chk("no update on reset release", upd_total, 0);

    // ---- table: acquisition, averaging, deadband, coast, lost ----
    add(1, 100, 50,   0,  0, 0, 1, 0);
    add(1, 100, 50,   0,  0, 0, 1, 0);
    add(1, 100, 50, 100, 50, 1, 2, 1);
    add(1, 101, 51, 100, 50, 1, 2, 0);
    add(1, 200, 50, 125, 50, 1, 2, 1);
    add(1, 200, 50, 150, 50, 1, 2, 1);
    add(1, 200, 50, 175, 50, 1, 2, 1);
    add(1, 200, 50, 200, 50, 1, 2, 1);
    add(1, 208, 50, 200, 50, 1, 2, 0);
    add(1, 204, 50, 203, 50, 1, 2, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 203, 50, 1, 3, 0);
    add(1, 200, 50, 203, 50, 1, 2, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 203, 50, 1, 3, 0);
    add(0, 0, 0, 203, 50, 0, 0, 0);
    add(1, 10, 10, 203, 50, 0, 1, 0);
    add(0, 0, 0, 203, 50, 0, 0, 0);
    add(1, 300, 300, 203, 50, 0, 1, 0);
    add(1, 300, 300, 203, 50, 0, 1, 0);
    add(1, 300, 300, 300, 300, 1, 2, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      frm(vecs[i].hit ? 1 : 0, vecs[i].x, vecs[i].y, 0, 0, 1'b0, 0, 0, upd);
      check_frame($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ea,
                  vecs[i].es, vecs[i].eu, upd);
    end

    // ---- range filter, last strobe wins, coincident strobe ----
    do_reset();
    frm(2, 700, 10, 300, 200, 1'b0, 0, 0, upd);
    check_frame("range f1", 0, 0, 0, 1, 0, upd);
    frm(2, 100, 100, 700, 10, 1'b0, 0, 0, upd);
    check_frame("range f2", 0, 0, 0, 1, 0, upd);
    frm(2, 120, 40, 300, 200, 1'b0, 0, 0, upd);
    check_frame("range f3", 250, 175, 1, 2, 1, upd);
    frm(0, 0, 0, 0, 0, 1'b1, 400, 300, upd);
    check_frame("coincident", 250, 175, 1, 3, 0, upd);
    frm(0, 0, 0, 0, 0, 1'b0, 0, 0, upd);
    check_frame("carried", 275, 200, 1, 2, 1, upd);
    for (int i = 0; i < 8; i++) frm(0, 0, 0, 0, 0, 1'b0, 0, 0, upd);
    check_frame("lost hold", 275, 200, 0, 0, 0, upd);
    frm(1, 500, 300, 0, 0, 1'b0, 0, 0, upd);
    check_frame("reacquire", 275, 200, 0, 1, 0, upd);

    // ---- asynchronous reset mid-ACQUIRE, with a pending sample ----
    tick();
    strobe(50, 60);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("async rst x_out", int'(x_out), 0);
    chk("async rst y_out", int'(y_out), 0);
    chk("async rst state_out", int'(state_out), 0);
    chk("async rst active_out", int'(active_out), 0);
    tick(); tick();
    #2 rst = 1'b0;
    frm(0, 0, 0, 0, 0, 1'b0, 0, 0, upd);
    check_frame("post rst sample cleared", 0, 0, 0, 0, 0, upd);
    frm(1, 30, 40, 0, 0, 1'b0, 0, 0, upd);
    check_frame("post rst hit1", 0, 0, 0, 1, 0, upd);
    frm(1, 30, 40, 0, 0, 1'b0, 0, 0, upd);
    check_frame("post rst hit2", 0, 0, 0, 1, 0, upd);
    // third hit: cycle-accurate latency check
    tick();
    base = upd_total;
    strobe(30, 40);
    tick();
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("t+1 state_out", int'(state_out), 2);
    chk("t+1 active_out", int'(active_out), 0);
    chk("t+1 update_out", int'(update_out), 0);
    tick();
    chk("t+2 active_out", int'(active_out), 1);
    chk("t+2 update_out", int'(update_out), 1);
    chk("t+2 x_out", int'(x_out), 30);
    chk("t+2 y_out", int'(y_out), 40);
    tick();
    chk("t+3 update_out", int'(update_out), 0);
    chk("third hit update pulses", upd_total - base, 1);

    // ---- randomized frames against the reference model ----
    do_reset();
    m_reset();
    thr = 80;
    for (int f = 0; f < 400; f++) begin
      if (f % 25 == 0) begin
        case ($urandom_range(0, 2))
          0: thr = 15;
          1: thr = 60;
          default: thr = 95;
        endcase
      end
      tick();
      base = upd_total;
      ns = (int'($urandom_range(0, 99)) < thr) ? int'($urandom_range(1, 3)) : 0;
      for (int s = 0; s < ns; s++) begin
        gen(sx, sy);
        strobe(sx, sy);
        m_strobe(sx, sy);
      end
      co = ($urandom_range(0, 9) == 0);
      cx = 0; cy = 0;
      if (co) gen(cx, cy);
      nf_pulse(co, cx, cy);
      tick();
      tick();
      m_frame();
      if (co) m_strobe(cx, cy);
      check_frame($sformatf("rnd%0d", f), m_x, m_y, m_act, m_state, m_upd, upd_total - base);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
